// File: rtl/axi_inval_bcast.sv
// axi_inval_bcast: forwards upstream AW requests downstream and, for every
// burst accepted while coherence is enabled, broadcasts L1 line invalidations
// covering the written byte region to the enabled harts, in push order.
module axi_inval_bcast #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned MaxTxns     = 4,
  parameter int unsigned NrHarts     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NrHarts-1:0]   en_i,
  input  logic                 slv_aw_valid_i,
  output logic                 slv_aw_ready_o,
  input  logic [AddrWidth-1:0] slv_aw_addr_i,
  input  logic [7:0]           slv_aw_len_i,
  input  logic [2:0]           slv_aw_size_i,
  input  logic [1:0]           slv_aw_burst_i,
  output logic                 mst_aw_valid_o,
  input  logic                 mst_aw_ready_i,
  output logic [AddrWidth-1:0] mst_aw_addr_o,
  output logic [7:0]           mst_aw_len_o,
  output logic [2:0]           mst_aw_size_o,
  output logic [1:0]           mst_aw_burst_o,
  output logic [NrHarts-1:0]   inval_valid_o,
  input  logic [NrHarts-1:0]   inval_ready_i,
  output logic [AddrWidth-1:0] inval_addr_o,
  output logic                 busy_o
);

  localparam int unsigned PtrW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned CntW = $clog2(MaxTxns + 1);
  localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineWidth);
  localparam logic [AddrWidth-1:0] LineMask = ~(LineStep - AddrWidth'(1));

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrWidth-1:0]   cur_q, cur_d, last_q, last_d;
  logic [NrHarts-1:0]     mask_q, mask_d, pend_q, pend_d, pend_left;

  logic [AddrWidth-1:0]   first_mem [MaxTxns];
  logic [AddrWidth-1:0]   last_mem  [MaxTxns];
  logic [NrHarts-1:0]     mask_mem  [MaxTxns];

  logic                   gate, push, pop;
  logic [AddrWidth-1:0]   beat_bytes, burst_bytes, region_bytes, base;
  logic [AddrWidth-1:0]   first_line, last_line;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTxns - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // AW pass-through, gated only when coherence is on and the queue is full
  always_comb begin
    gate           = (en_i == '0) || (count_q != CntW'(MaxTxns));
    mst_aw_valid_o = slv_aw_valid_i && gate;
    slv_aw_ready_o = mst_aw_ready_i && gate;
    mst_aw_addr_o  = slv_aw_addr_i;
    mst_aw_len_o   = slv_aw_len_i;
    mst_aw_size_o  = slv_aw_size_i;
    mst_aw_burst_o = slv_aw_burst_i;
    push           = slv_aw_valid_i && slv_aw_ready_o && (en_i != '0);
    pop            = (state_q == IDLE) && (count_q != '0);
  end

  // Byte region touched by the incoming burst, reduced to first/last line
  always_comb begin
    beat_bytes  = AddrWidth'(1) << slv_aw_size_i;
    burst_bytes = (AddrWidth'(slv_aw_len_i) + AddrWidth'(1)) << slv_aw_size_i;
    case (slv_aw_burst_i)
      2'd0: begin
        region_bytes = beat_bytes;
        base         = slv_aw_addr_i & ~(beat_bytes - AddrWidth'(1));
      end
      2'd2: begin
        region_bytes = burst_bytes;
        base         = slv_aw_addr_i & ~(burst_bytes - AddrWidth'(1));
      end
      default: begin
        region_bytes = burst_bytes;
        base         = slv_aw_addr_i & ~(beat_bytes - AddrWidth'(1));
      end
    endcase
    first_line = base & LineMask;
    last_line  = (base + region_bytes - AddrWidth'(1)) & LineMask;
  end

  // Queue pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
  end

  // Queue storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push) begin
      first_mem[wr_ptr_q] <= first_line;
      last_mem[wr_ptr_q]  <= last_line;
      mask_mem[wr_ptr_q]  <= en_i;
    end
  end

  // Engine: walk each popped entry line by line until every masked hart acked
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    pend_left = pend_q & ~inval_ready_i;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
          cur_d   = first_mem[rd_ptr_q];
          last_d  = last_mem[rd_ptr_q];
          mask_d  = mask_mem[rd_ptr_q];
          pend_d  = mask_mem[rd_ptr_q];
        end
      end
      ISSUE: begin
        if (pend_left == '0) begin
          if (cur_q == last_q) begin
            state_d = IDLE;
            pend_d  = '0;
          end else begin
            cur_d  = cur_q + LineStep;
            pend_d = mask_q;
          end
        end else begin
          pend_d = pend_left;
        end
      end
    endcase
  end

  // State registers with synchronous reset discarding all queued work
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cur_q    <= '0;
      last_q   <= '0;
      mask_q   <= '0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
    end
  end

  // Outputs come straight from registered engine state
  always_comb begin
    inval_valid_o = (state_q == ISSUE) ? pend_q : '0;
    inval_addr_o  = cur_q;
    busy_o        = (count_q != '0) || (state_q != IDLE);
  end

endmodule

// File: tb/tb_axi_inval_bcast.sv
// Self-checking bench for axi_inval_bcast with a queue-based reference model.
module tb_axi_inval_bcast;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en = 2'b00;
  logic        aw_valid = 1'b0;
  logic        slv_aw_ready_o;
  logic [63:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic        mst_aw_valid_o;
  logic        mst_aw_ready = 1'b1;
  logic [63:0] mst_aw_addr_o;
  logic [7:0]  mst_aw_len_o;
  logic [2:0]  mst_aw_size_o;
  logic [1:0]  mst_aw_burst_o;
  logic [1:0]  inval_valid_o;
  logic [1:0]  inval_ready = 2'b11;
  logic [63:0] inval_addr_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_inval_bcast #(
    .AddrWidth(64), .L1LineWidth(16), .MaxTxns(4), .NrHarts(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(slv_aw_ready_o),
    .slv_aw_addr_i(aw_addr), .slv_aw_len_i(aw_len),
    .slv_aw_size_i(aw_size), .slv_aw_burst_i(aw_burst),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready),
    .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_len_o(mst_aw_len_o),
    .mst_aw_size_o(mst_aw_size_o), .mst_aw_burst_o(mst_aw_burst_o),
    .inval_valid_o(inval_valid_o), .inval_ready_i(inval_ready),
    .inval_addr_o(inval_addr_o), .busy_o(busy_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, expected event did not occur", nm);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] first;
    logic [63:0] last;
    logic [1:0]  mask;
  } ent_t;

  ent_t        mq[$];
  bit          mdl_on = 0;
  bit          m_active = 0;
  logic [63:0] m_cur = '0, m_last = '0;
  logic [1:0]  m_mask = '0, m_pend = '0;

  function automatic void region(input logic [63:0] a, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] bt,
                                 output logic [63:0] f, output logic [63:0] l);
    logic [63:0] beat, nb, base, end_b;
    beat  = 64'd1 << size;
    nb    = (bt == 2'd0) ? beat : (64'(len) + 64'd1) * beat;
    base  = (bt == 2'd2) ? a - (a % nb) : a - (a % beat);
    end_b = base + nb - 64'd1;
    f     = base - (base % 64'd16);
    l     = end_b - (end_b % 64'd16);
  endfunction

  initial begin
    ent_t e;
    bit   hs;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_active = 0;
        m_pend   = '0;
        m_cur    = '0;
        mdl_on   = 1;
      end else begin
        hs = aw_valid && mst_aw_ready && ((en == 2'b00) || (mq.size() < 4));
        if (!m_active) begin
          if (mq.size() > 0) begin
            e        = mq.pop_front();
            m_active = 1;
            m_cur    = e.first;
            m_last   = e.last;
            m_mask   = e.mask;
            m_pend   = e.mask;
          end
        end else begin
          m_pend = m_pend & ~inval_ready;
          if (m_pend == 2'b00) begin
            if (m_cur == m_last) m_active = 0;
            else begin
              m_cur  = m_cur + 64'd16;
              m_pend = m_mask;
            end
          end
        end
        if (hs && en != 2'b00) begin
          region(aw_addr, aw_len, aw_size, aw_burst, e.first, e.last);
          e.mask = en;
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    logic [1:0] exp_v;
    bit         g;
    forever begin
      @(negedge clk);
      if (mdl_on) begin
        g     = (en == 2'b00) || (mq.size() < 4);
        exp_v = m_active ? m_pend : 2'b00;
        chk("slv_aw_ready", 64'(slv_aw_ready_o), 64'(mst_aw_ready && g));
        chk("mst_aw_valid", 64'(mst_aw_valid_o), 64'(aw_valid && g));
        chk("mst_aw_addr", mst_aw_addr_o, aw_addr);
        chk("mst_aw_ctl", 64'({mst_aw_len_o, mst_aw_size_o, mst_aw_burst_o}),
            64'({aw_len, aw_size, aw_burst}));
        chk("busy", 64'(busy_o), 64'(mq.size() > 0 || m_active));
        chk("inval_valid", 64'(inval_valid_o), 64'(exp_v));
        if (exp_v != 2'b00) chk("inval_addr", inval_addr_o, m_cur);
      end
    end
  end

  // Handshake log per hart for literal expectations
  logic [63:0] log0[$], log1[$];
  logic [63:0] exp_l [6];

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (inval_valid_o[0] && inval_ready[0]) log0.push_back(inval_addr_o);
        if (inval_valid_o[1] && inval_ready[1]) log1.push_back(inval_addr_o);
      end
    end
  end

  task automatic chk_log(input string nm, input int h, input int n);
    int sz;
    sz = (h == 0) ? log0.size() : log1.size();
    chk({nm, "_count"}, 64'(sz), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < sz) chk({nm, "_addr"}, (h == 0) ? log0[i] : log1[i], exp_l[i]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic start_aw(input logic [63:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    aw_addr  = a;
    aw_len   = l;
    aw_size  = s;
    aw_burst = b;
    aw_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic finish_aw(input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (slv_aw_ready_o) done = 1;
    end
    if (!done) timeout_fail(nm);
    @(posedge clk);
    #1;
    aw_valid = 1'b0;
  endtask

  task automatic send_aw(input logic [63:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    start_aw(a, l, s, b);
    finish_aw("aw_accept");
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy_o) done = 1;
    end
    if (!done) timeout_fail(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (inval_valid_o != 2'b00) done = 1;
    end
    if (!done) timeout_fail(nm);
  endtask

  task automatic new_scenario;
    @(posedge clk);
    #1;
    log0.delete();
    log1.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(inval_valid_o), 64'h0);
    chk("rst_addr", inval_addr_o, 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);

    // 1: INCR 0x1000 len3 size3, hart0 only, 2-cycle latency
    new_scenario();
    en = 2'b01;
    inval_ready = 2'b11;
    send_aw(64'h1000, 8'd3, 3'd3, 2'd1);
    @(negedge clk);
    chk("lat_cycle1_valid", 64'(inval_valid_o), 64'h0);
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(inval_valid_o), 64'h1);
    chk("lat_cycle2_addr", inval_addr_o, 64'h1000);
    wait_idle("idle_s1");
    exp_l = '{64'h1000, 64'h1010, 0, 0, 0, 0};
    chk_log("s1_h0", 0, 2);
    chk_log("s1_h1", 1, 0);

    // 2: unaligned INCR crossing a line, then FIXED within one line
    new_scenario();
    send_aw(64'h100C, 8'd1, 3'd2, 2'd1);
    send_aw(64'h100C, 8'd0, 3'd3, 2'd0);
    wait_idle("idle_s2");
    exp_l = '{64'h1000, 64'h1010, 64'h1000, 0, 0, 0};
    chk_log("s2_h0", 0, 3);

    // 3: WRAP region, en changed after push must not affect the entry
    new_scenario();
    send_aw(64'h1028, 8'd3, 3'd3, 2'd2);
    en = 2'b10;
    wait_idle("idle_s3");
    exp_l = '{64'h1020, 64'h1030, 0, 0, 0, 0};
    chk_log("s3_h0", 0, 2);
    chk_log("s3_h1", 1, 0);

    // 4: stalled harts fill the queue; sixth AW blocks until a line completes
    new_scenario();
    en = 2'b11;
    inval_ready = 2'b00;
    for (int i = 0; i < 5; i++) send_aw(64'h2000 + 64'(i) * 64'h10, 8'd0, 3'd3, 2'd1);
    start_aw(64'h2050, 8'd0, 3'd3, 2'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_aw_ready", 64'(slv_aw_ready_o), 64'h0);
      chk("full_mst_valid", 64'(mst_aw_valid_o), 64'h0);
    end
    @(posedge clk);
    #1;
    inval_ready = 2'b11;
    finish_aw("sixth_accept");
    wait_idle("idle_s4");
    exp_l = '{64'h2000, 64'h2010, 64'h2020, 64'h2030, 64'h2040, 64'h2050};
    chk_log("s4_h0", 0, 6);
    chk_log("s4_h1", 1, 6);

    // 5: hart1 acks late; line must hold until it does
    new_scenario();
    en = 2'b11;
    inval_ready = 2'b01;
    send_aw(64'h3000, 8'd1, 3'd4, 2'd1);
    wait_valid("s5_valid");
    chk("s5_c1_valid", 64'(inval_valid_o), 64'h3);
    chk("s5_c1_addr", inval_addr_o, 64'h3000);
    @(negedge clk);
    chk("s5_c2_valid", 64'(inval_valid_o), 64'h2);
    chk("s5_c2_addr", inval_addr_o, 64'h3000);
    @(negedge clk);
    chk("s5_c3_valid", 64'(inval_valid_o), 64'h2);
    @(posedge clk);
    #1;
    inval_ready = 2'b11;
    @(negedge clk);
    chk("s5_c4_valid", 64'(inval_valid_o), 64'h2);
    chk("s5_c4_addr", inval_addr_o, 64'h3000);
    @(negedge clk);
    chk("s5_c5_valid", 64'(inval_valid_o), 64'h3);
    chk("s5_c5_addr", inval_addr_o, 64'h3010);
    wait_idle("idle_s5");
    exp_l = '{64'h3000, 64'h3010, 0, 0, 0, 0};
    chk_log("s5_h0", 0, 2);
    chk_log("s5_h1", 1, 2);

    // 6a: coherence disabled, AW purely mirrored
    new_scenario();
    en = 2'b00;
    mst_aw_ready = 1'b0;
    start_aw(64'h5000, 8'd3, 3'd3, 2'd1);
    @(negedge clk);
    chk("dis_ready_low", 64'(slv_aw_ready_o), 64'h0);
    chk("dis_valid_fwd", 64'(mst_aw_valid_o), 64'h1);
    @(posedge clk);
    #1;
    mst_aw_ready = 1'b1;
    @(negedge clk);
    chk("dis_ready_high", 64'(slv_aw_ready_o), 64'h1);
    @(posedge clk);
    #1;
    aw_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_busy", 64'(busy_o), 64'h0);
    chk_log("s6a_h0", 0, 0);

    // 6b: reset mid-burst discards in-flight and pending lines
    new_scenario();
    en = 2'b01;
    inval_ready = 2'b00;
    send_aw(64'h4000, 8'd7, 3'd4, 2'd1);
    wait_valid("s6b_valid");
    @(posedge clk);
    #1;
    inval_ready = 2'b01;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(inval_valid_o), 64'h0);
    chk("midrst_busy", 64'(busy_o), 64'h0);
    chk("midrst_addr", inval_addr_o, 64'h0);
    repeat (10) @(negedge clk);
    exp_l = '{64'h4000, 64'h4010, 0, 0, 0, 0};
    chk_log("s6b_h0", 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
